// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and constants for the branch resolve queue.
package branch_resolve_queue_pkg;

    localparam int unsigned LOW_ADDR_WIDTH_DFLT = 8;
    localparam int unsigned DEPTH_LOG2_DFLT     = 2;
    localparam int unsigned ENTRY_W             = LOW_ADDR_WIDTH_DFLT + 1;
    localparam int unsigned STAT_W              = 16;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } dir_e;

    typedef struct packed {
        logic [LOW_ADDR_WIDTH_DFLT-1:0] addr;
        dir_e                           predict;
    } brq_entry_t;

    // Increment that sticks at all-ones.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/brq_fifo_mem.sv
// Circular entry storage with head/tail pointers, occupancy count and a
// single-cycle clear that overrides any same-cycle push.
module brq_fifo_mem #(
    parameter int unsigned W          = 9,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_clear,
    input  logic [W-1:0]          i_wdata,
    output logic [W-1:0]          o_rdata,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_empty,
    output logic                  o_full
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [W-1:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_head;
    logic [DEPTH_LOG2-1:0] r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_empty;
    logic                  r_full;
    logic [CW-1:0]         w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        if (i_clear) begin
            w_count_nxt = '0;
        end else begin
            case ({i_push, i_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (i_clear) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                if (i_pop)  r_head <= r_head + DEPTH_LOG2'(1);
                if (i_push) r_tail <= r_tail + DEPTH_LOG2'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    // Data array carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (i_push && !i_clear) r_mem[r_tail] <= i_wdata;
    end

    assign o_rdata = r_mem[r_head];
    assign o_count = r_count;
    assign o_empty = r_empty;
    assign o_full  = r_full;

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches feeding the predictor renew port.
// Define BRANCH_RESOLVE_STATS_EN to build saturating resolve/mispredict counters.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int unsigned LOW_ADDR_WIDTH = LOW_ADDR_WIDTH_DFLT,
    parameter int unsigned DEPTH_LOG2     = DEPTH_LOG2_DFLT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [LOW_ADDR_WIDTH-1:0] push_addr,
    input  logic                      push_predict,
    input  logic                      resolve_valid,
    input  logic                      resolve_result,
    input  logic                      flush,
    output logic                      renew_valid,
    output logic [LOW_ADDR_WIDTH-1:0] renew_addr,
    output logic                      last_predict,
    output logic                      renew_result,
    output logic                      mispredict,
    output logic [DEPTH_LOG2:0]       count,
    output logic                      empty,
    output logic                      full,
    output logic                      resolve_err,
    output logic [STAT_W-1:0]         stat_resolve_cnt,
    output logic [STAT_W-1:0]         stat_mispredict_cnt
);

    localparam int unsigned EW = LOW_ADDR_WIDTH + 1;

    logic [EW-1:0]             w_rdata;
    logic [LOW_ADDR_WIDTH-1:0] w_head_addr;
    logic                      w_head_pred;
    logic                      w_pop;
    logic                      w_mis;
    logic                      w_push;

    logic                      r_renew_valid;
    logic [LOW_ADDR_WIDTH-1:0] r_renew_addr;
    logic                      r_last_predict;
    logic                      r_renew_result;
    logic                      r_mispredict;
    logic                      r_resolve_err;

    assign w_head_addr = w_rdata[EW-1:1];
    assign w_head_pred = w_rdata[0];
    assign w_pop       = resolve_valid && !empty;
    assign w_mis       = w_pop && (w_head_pred != resolve_result);
    // Wrong-path or flushed pushes are dropped in the cycle they arrive.
    assign w_push      = push_valid && push_ready && !w_mis && !flush;

    brq_fifo_mem #(
        .W          (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (flush || w_mis),
        .i_wdata ({push_addr, push_predict}),
        .o_rdata (w_rdata),
        .o_count (count),
        .o_empty (empty),
        .o_full  (full)
    );

    assign push_ready = !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_renew_valid  <= 1'b0;
            r_renew_addr   <= '0;
            r_last_predict <= 1'b0;
            r_renew_result <= 1'b0;
            r_mispredict   <= 1'b0;
            r_resolve_err  <= 1'b0;
        end else begin
            r_renew_valid <= w_pop;
            r_mispredict  <= w_mis;
            if (w_pop) begin
                r_renew_addr   <= w_head_addr;
                r_last_predict <= w_head_pred;
                r_renew_result <= resolve_result;
            end
            if (resolve_valid && empty) r_resolve_err <= 1'b1;
        end
    end

    assign renew_valid  = r_renew_valid;
    assign renew_addr   = r_renew_addr;
    assign last_predict = r_last_predict;
    assign renew_result = r_renew_result;
    assign mispredict   = r_mispredict;
    assign resolve_err  = r_resolve_err;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [STAT_W-1:0] r_stat_res;
    logic [STAT_W-1:0] r_stat_mis;

    // Counts land on the same edge that raises renew_valid/mispredict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_res <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_pop) r_stat_res <= sat_inc(r_stat_res);
            if (w_mis) r_stat_mis <= sat_inc(r_stat_mis);
        end
    end

    assign stat_resolve_cnt    = r_stat_res;
    assign stat_mispredict_cnt = r_stat_mis;
`else
    assign stat_resolve_cnt    = '0;
    assign stat_mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: a queue model predicts renews.
module tb_branch_resolve_queue;
    import branch_resolve_queue_pkg::*;

    localparam int AW    = 8;
    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [AW-1:0] push_addr;
    logic          push_predict;
    logic          resolve_valid;
    logic          resolve_result;
    logic          flush;
    logic          renew_valid;
    logic [AW-1:0] renew_addr;
    logic          last_predict;
    logic          renew_result;
    logic          mispredict;
    logic [DL:0]   count;
    logic          empty;
    logic          full;
    logic          resolve_err;
    logic [STAT_W-1:0] stat_resolve_cnt;
    logic [STAT_W-1:0] stat_mispredict_cnt;

    branch_resolve_queue #(.LOW_ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .push_valid          (push_valid),
        .push_ready          (push_ready),
        .push_addr           (push_addr),
        .push_predict        (push_predict),
        .resolve_valid       (resolve_valid),
        .resolve_result      (resolve_result),
        .flush               (flush),
        .renew_valid         (renew_valid),
        .renew_addr          (renew_addr),
        .last_predict        (last_predict),
        .renew_result        (renew_result),
        .mispredict          (mispredict),
        .count               (count),
        .empty               (empty),
        .full                (full),
        .resolve_err         (resolve_err),
        .stat_resolve_cnt    (stat_resolve_cnt),
        .stat_mispredict_cnt (stat_mispredict_cnt)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          pred;
    } ent_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic          pred;
        logic          res;
        logic          mis;
    } ren_t;

    ent_t m_q[$];
    ren_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic m_err;
    int   m_res_cnt;
    int   m_mis_cnt;
    logic [AW-1:0] last_addr;
    logic last_pred;
    logic last_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic head_pred();
        return (m_q.size() > 0) ? m_q[0].pred : 1'b0;
    endfunction

    task automatic check_state();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("push_ready", 32'(push_ready), 32'(m_q.size() != DEPTH));
        chk("resolve_err", 32'(resolve_err), 32'(m_err));
`ifdef BRANCH_RESOLVE_STATS_EN
        chk("stat_res", 32'(stat_resolve_cnt), 32'(m_res_cnt));
        chk("stat_mis", 32'(stat_mispredict_cnt), 32'(m_mis_cnt));
`else
        chk("stat_res", 32'(stat_resolve_cnt), 32'd0);
        chk("stat_mis", 32'(stat_mispredict_cnt), 32'd0);
`endif
    endtask

    // Drive one cycle of stimulus and advance the reference model.
    task automatic step(input logic pv, input logic [AW-1:0] a, input logic p,
                        input logic rv, input logic r, input logic fl);
        ent_t e;
        bit   full_b;
        bit   mis;
        push_valid     = pv;
        push_addr      = a;
        push_predict   = p;
        resolve_valid  = rv;
        resolve_result = r;
        flush          = fl;
        full_b = (m_q.size() == DEPTH);
        mis    = 1'b0;
        if (rv && m_q.size() > 0) begin
            e   = m_q.pop_front();
            mis = (e.pred != r);
            sb.push_back('{e.addr, e.pred, r, mis});
            if (m_res_cnt < 65535) m_res_cnt++;
            if (mis && m_mis_cnt < 65535) m_mis_cnt++;
        end else if (rv) begin
            m_err = 1'b1;
        end
        if (fl || mis) m_q.delete();
        else if (pv && !full_b) m_q.push_back('{a, p});
        @(posedge clk);
        #1;
        push_valid    = 1'b0;
        resolve_valid = 1'b0;
        flush         = 1'b0;
        check_state();
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Renew monitor: every strobe must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (renew_valid) begin
                if (sb.size() == 0) begin
                    chk("renew_unexpected", 32'd1, 32'd0);
                end else begin
                    ren_t x;
                    x = sb.pop_front();
                    chk("renew_addr", 32'(renew_addr), 32'(x.addr));
                    chk("last_predict", 32'(last_predict), 32'(x.pred));
                    chk("renew_result", 32'(renew_result), 32'(x.res));
                    chk("mispredict", 32'(mispredict), 32'(x.mis));
                    last_addr = x.addr;
                    last_pred = x.pred;
                    last_res  = x.res;
                end
            end else begin
                chk("mispredict_idle", 32'(mispredict), 32'd0);
                chk("renew_addr_hold", 32'(renew_addr), 32'(last_addr));
                chk("last_predict_hold", 32'(last_predict), 32'(last_pred));
                chk("renew_result_hold", 32'(renew_result), 32'(last_res));
            end
        end
    end

    initial begin
        rst = 1'b1;
        push_valid = 1'b0; push_addr = '0; push_predict = 1'b0;
        resolve_valid = 1'b0; resolve_result = 1'b0; flush = 1'b0;
        m_err = 1'b0; m_res_cnt = 0; m_mis_cnt = 0;
        last_addr = '0; last_pred = 1'b0; last_res = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_renew_valid", 32'(renew_valid), 32'd0);
        chk("rst_renew_addr", 32'(renew_addr), 32'd0);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        check_state();

        // Basic in-order resolve, both correct.
        step(1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        // Fill to full; a fifth push is ignored.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);

        // Full with push held plus one resolve, then the push goes in.
        step(1'b1, 8'h51, 1'b0, 1'b1, head_pred(), 1'b0);
        step(1'b1, 8'h51, 1'b0, 1'b0, 1'b0, 1'b0);
        while (m_q.size() > 0) step(1'b0, 8'h00, 1'b0, 1'b1, head_pred(), 1'b0);
        idle();

        // Streaming push+resolve across pointer wrap.
        for (int i = 0; i < 10; i++)
            step(1'b1, 8'h80 + 8'(i), 1'(i % 3 == 0), i > 0, head_pred(), 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, head_pred(), 1'b0);
        idle();

        // Mispredict squashes younger entries and a same-cycle push.
        step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        // Resolve on empty, then flush with resolve and push together.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b1, 1'b1, head_pred(), 1'b1);
        idle();

        // Five resolves, two of them mispredicted.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b1, (i == 1 || i == 3) ? 1'b0 : 1'b1, 1'b0);
        end
        idle();

        // Asynchronous reset while a renew is on the outputs.
        step(1'b1, 8'hD0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hD1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_renew_valid", 32'(renew_valid), 32'd1);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        m_q.delete();
        m_err = 1'b0; m_res_cnt = 0; m_mis_cnt = 0;
        last_addr = '0; last_pred = 1'b0; last_res = 1'b0;
        #1;
        chk("async_renew_valid", 32'(renew_valid), 32'd0);
        chk("async_renew_addr", 32'(renew_addr), 32'd0);
        chk("async_last_predict", 32'(last_predict), 32'd0);
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();
        step(1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order queue of in-flight conditional-branch predictions, placed between fetch and the local branch predictor's renew port.
- Fetch pushes each predicted branch (low PC bits plus predicted direction); execute resolves branches oldest-first.
- On each resolution the queue drives one registered renew transaction into the predictor and flags a mispredict.
- On a mispredict it discards all younger (wrong-path) entries.

Parameters:
- LOW_ADDR_WIDTH, 8, low PC bits indexing the predictor history table.
- DEPTH_LOG2, 2, log2 of queue depth (depth = 2**DEPTH_LOG2 = 4).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- push_valid  in  1  fetch offers a predicted branch.
- push_ready  out  1  queue can accept; equals !full, with no same-cycle pop bypass.
- push_addr  in  LOW_ADDR_WIDTH  branch low PC bits.
- push_predict  in  1  direction predicted at fetch (1 = taken).
- resolve_valid  in  1  execute resolves the oldest branch.
- resolve_result  in  1  actual direction.
- flush  in  1  external pipeline flush; clears the queue.
- renew_valid  out  1  registered one-cycle update strobe to the predictor.
- renew_addr  out  LOW_ADDR_WIDTH  address of the resolved entry.
- last_predict  out  1  stored prediction of the resolved entry.
- renew_result  out  1  actual direction.
- mispredict  out  1  registered one-cycle pulse, aligned with renew_valid.
- count  out  DEPTH_LOG2+1  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == depth.
- resolve_err  out  1  sticky; set when a resolve arrives while the queue is empty.

Behaviour:
- Storage: circular buffer of {addr, predict}, with head/tail pointers of DEPTH_LOG2 bits that wrap modulo depth. count is held as a separate register.
- Reset values:
  - Pointers and count = 0; empty = 1; full = 0; push_ready = 1.
  - renew_valid, renew_addr, last_predict, renew_result, mispredict, resolve_err = 0.
- Push: accepted when push_valid && push_ready. The entry is written at tail, then tail and count increment.
- Resolve: when resolve_valid && !empty, the head entry pops; head increments and count decrements. Next cycle (latency 1):
  - renew_valid = 1
  - renew_addr = entry.addr
  - last_predict = entry.predict
  - renew_result = resolve_result
  - mispredict = (entry.predict != resolve_result)
- Outside the resolve cycle, renew_valid and mispredict drop to 0. The data outputs hold their last values.
- Resolve while empty: no pop, no renew_valid; resolve_err sets. resolve_err is cleared only by rst.
- Simultaneous push and resolve with no mispredict and no flush: both are performed and count is unchanged. This is legal even when full, but push_ready still reads 0 when full, so no push occurs then.
- Mispredicting resolve: after the pop, the queue clears (head = tail = 0, count = 0). A push in the same cycle is dropped.
- flush = 1: the queue clears. A resolve in the same cycle still pops head and emits its renew/mispredict. A push in the same cycle is dropped.
- Overflow is impossible, because push is gated by push_ready. Pointer wrap-around is transparent.
- Asserting rst mid-operation discards all entries immediately, including any renew not yet emitted.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined: two 16-bit saturating counters, output as stat_resolve_cnt and stat_mispredict_cnt.
  - Each increments on the cycle a renew (respectively a mispredict) is emitted.
  - Each holds at 16'hFFFF once reached; reset value is 0.
- When undefined: both ports exist and are tied to 0, so the port list stays stable. No counter flops are built.

Decomposition:
- Shared package:
  - Entry struct/width constant: ENTRY_W = LOW_ADDR_WIDTH + 1.
  - Direction encodings: TAKEN = 1, NOT_TAKEN = 0.
  - STAT_W = 16.
- One sub-module is natural: brq_fifo_mem, holding storage and pointer/count logic with a clear port. The top level keeps the resolve, mispredict and renew output registers.

Test Plan:
- Reset, then push addr 0x12/pred 1, 0x34/pred 0; count = 2. Resolve 1, then resolve 0.
  - Expected: two renew pulses, (0x12,1,1) and (0x34,0,0); mispredict stays 0; empty = 1 afterwards.
- Push 4 entries.
  - Expected: full = 1, push_ready = 0; a 5th push is ignored and count stays 4.
- With full, hold push_valid and resolve once.
  - Expected: count = 3 next cycle, then the push is accepted back to 4. Verify pointer wrap by pushing and resolving 10 entries in sequence, with outputs in FIFO order.
- Push 0x01/pred 1, 0x02/pred 1, 0x03/pred 0; resolve 0.
  - Expected: renew (0x01,1,0) with mispredict = 1; count = 0 next cycle; entries 0x02 and 0x03 are never renewed.
- Resolve on an empty queue.
  - Expected: resolve_err = 1 and no renew_valid. Then flush with 2 entries plus a same-cycle resolve: one renew is emitted, count = 0, and a same-cycle push is dropped.
- Macro defined: 5 resolves with 2 mispredicts give stat_resolve_cnt = 5 and stat_mispredict_cnt = 2. Assert rst mid-stream: all counters and outputs return to 0 asynchronously.
